// File: rtl/calc_pkg.sv
// Shared calculator definitions: key indices, 10-bit button codes and the
// keypad encoder state encoding. math_calculator_fsm imports the same codes.
package calc_pkg;

    localparam int KEY_DIG0  = 0;
    localparam int KEY_DIG1  = 1;
    localparam int KEY_DIG2  = 2;
    localparam int KEY_DIG3  = 3;
    localparam int KEY_DIG4  = 4;
    localparam int KEY_DIG5  = 5;
    localparam int KEY_DIG6  = 6;
    localparam int KEY_DIG7  = 7;
    localparam int KEY_DIG8  = 8;
    localparam int KEY_DIG9  = 9;
    localparam int KEY_ADD   = 10;
    localparam int KEY_SUB   = 11;
    localparam int KEY_MUL   = 12;
    localparam int KEY_DIV   = 13;
    localparam int KEY_EQUAL = 14;
    localparam int KEY_CLEAR = 15;

    localparam logic [9:0] BTN_ADD   = 10'b10_0000_0001;
    localparam logic [9:0] BTN_SUB   = 10'b10_0000_0010;
    localparam logic [9:0] BTN_MUL   = 10'b10_0000_0100;
    localparam logic [9:0] BTN_DIV   = 10'b10_0000_1000;
    localparam logic [9:0] BTN_EQUAL = 10'b11_0000_0000;
    localparam logic [9:0] BTN_CLEAR = 10'b11_1000_0000;

    // Digits 0..8 are one-hot; 9 borrows bit 9 alone, which operators extend.
    function automatic logic [9:0] BTN_DIG(input logic [3:0] n);
        return (n == 4'd9) ? 10'b10_0000_0000 : (10'd1 << n);
    endfunction

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/key_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs.
module key_sync #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/calc_keypad_encoder.sv
// Keypad front end: synchronise, arbitrate and debounce 16 raw keys, emitting
// one single-cycle button code per accepted press.
module calc_keypad_encoder
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_raw,
    output logic [9:0]  button,
    output logic        button_valid,
    output logic        key_held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0] w_key_s;

    key_sync #(.W(16)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (key_raw),
        .o_sync  (w_key_s)
    );

    // CLEAR beats everything; otherwise the lowest set index wins.
    function automatic logic [3:0] arb_winner(input logic [15:0] k);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 14; i >= 0; i--)
            if (k[i]) r = 4'(i);
        if (k[KEY_CLEAR]) r = 4'(KEY_CLEAR);
        return r;
    endfunction

    function automatic logic [9:0] code_of(input logic [3:0] idx);
        logic [9:0] c;
        case (idx)
            4'd10:   c = BTN_ADD;
            4'd11:   c = BTN_SUB;
            4'd12:   c = BTN_MUL;
            4'd13:   c = BTN_DIV;
            4'd14:   c = BTN_EQUAL;
            4'd15:   c = BTN_CLEAR;
            default: c = BTN_DIG(idx);
        endcase
        return c;
    endfunction

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic [3:0]       r_idx,   w_idx;
    logic [9:0]       r_button, w_button;
    logic             r_valid, w_valid;
    logic             r_held,  w_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_button <= '0;
            r_valid  <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_button <= w_button;
            r_valid  <= w_valid;
            r_held   <= w_held;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_idx    = r_idx;
        w_button = '0;
        w_valid  = 1'b0;
        w_held   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_key_s) begin
                    w_idx   = arb_winner(w_key_s);
                    w_cnt   = '0;
                    w_state = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!w_key_s[r_idx]) begin
                    w_state = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_button = code_of(r_idx);
                    w_valid  = 1'b1;
                    w_held   = 1'b1;
                    w_state  = HOLD;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                // Any key still down keeps us here; nothing is queued.
                if (w_key_s == '0) begin
                    w_cnt   = '0;
                    w_state = RELEASE;
                end else begin
                    w_held = 1'b1;
                end
            end
            RELEASE: begin
                if (|w_key_s) begin
                    w_cnt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state = IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign button       = r_button;
    assign button_valid = r_valid;
    assign key_held     = r_held;

endmodule

// File: tb/tb_calc_keypad_encoder.sv
// Randomised and directed bench for calc_keypad_encoder against a
// timeline-scanning reference model of the press/release rules.
module tb_calc_keypad_encoder;

    localparam int D    = 4;
    localparam int MAXN = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] key_raw = '0;
    logic [9:0]  button;
    logic        button_valid;
    logic        key_held;

    calc_keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_raw      (key_raw),
        .button       (button),
        .button_valid (button_valid),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int nfill;
    int scen = 0;

    logic [15:0] raw [MAXN];
    logic [9:0]  eb  [MAXN];
    bit          eh  [MAXN];
    logic [9:0]  ob  [MAXN];
    bit          ov  [MAXN];
    bit          oh  [MAXN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [15:0] v, input int len);
        for (int i = 0; i < len; i++)
            if (nfill < MAXN) begin
                raw[nfill] = v;
                nfill++;
            end
    endtask

    function automatic logic [9:0] ref_code(input int k);
        case (k)
            9:       return 10'b10_0000_0000;
            10:      return 10'b10_0000_0001;
            11:      return 10'b10_0000_0010;
            12:      return 10'b10_0000_0100;
            13:      return 10'b10_0000_1000;
            14:      return 10'b11_0000_0000;
            15:      return 10'b11_1000_0000;
            default: return 10'd1 << k;
        endcase
    endfunction

    function automatic int ref_arb(input logic [15:0] v);
        if (v[15]) return 15;
        for (int i = 0; i < 15; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // Key vector the logic sees at edge e: raw delayed by two synchroniser edges.
    function automatic logic [15:0] ks(input int e);
        return (e >= 2) ? raw[e-2] : 16'h0;
    endfunction

    // Scan the synced timeline: find each press start, require D stable
    // cycles of the winner, then the full release, and mark outputs.
    task automatic run_model(input int n);
        int t, k, h, e, run, w;
        bit ok;
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            eb[i] = '0;
            eh[i] = 1'b0;
        end
        t = 0;
        while (t < n) begin
            if (ks(t) == 16'h0) begin
                t++;
                continue;
            end
            w  = ref_arb(ks(t));
            ok = 1'b1;
            for (k = 1; k <= D; k++) begin
                if (t + k >= n) return;
                v = ks(t + k);
                if (!v[w]) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (!ok) begin
                t = t + k + 1;
                continue;
            end
            eb[t+D] = ref_code(w);
            h = t + D + 1;
            while (h < n && ks(h) != 16'h0) h++;
            for (int c = t + D; c < h && c < n; c++) eh[c] = 1'b1;
            if (h >= n) return;
            run = 0;
            e = h + 1;
            while (e < n) begin
                if (ks(e) == 16'h0) run++;
                else run = 0;
                if (run == D) break;
                e++;
            end
            t = e + 1;
        end
    endtask

    task automatic run_scen(input int n);
        rst = 1'b1;
        key_raw = raw[0];
        @(negedge clk);
        #1;
        chk($sformatf("s%0d reset button", scen), 32'(button), 32'h0);
        chk($sformatf("s%0d reset valid", scen), 32'(button_valid), 32'h0);
        chk($sformatf("s%0d reset held", scen), 32'(key_held), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            key_raw = raw[c];
            @(posedge clk);
            #1;
            ob[c] = button;
            ov[c] = button_valid;
            oh[c] = key_held;
            @(negedge clk);
        end
        run_model(n);
        for (int c = 0; c < n; c++) begin
            chk($sformatf("s%0d c%0d button", scen, c), 32'(ob[c]), 32'(eb[c]));
            chk($sformatf("s%0d c%0d valid", scen, c), 32'(ov[c]), 32'(eb[c] != 10'd0));
            chk($sformatf("s%0d c%0d held", scen, c), 32'(oh[c]), 32'(eh[c]));
        end
        scen++;
    endtask

    initial begin
        logic [15:0] v;
        int r;

        // Key 5 clean press.
        nfill = 0; add(16'h0, 2); add(16'h0020, 20); add(16'h0, 10);
        run_scen(nfill);

        // Key 7 short bounce, then a clean press.
        nfill = 0; add(16'h0080, 3); add(16'h0, 6); add(16'h0080, 10); add(16'h0, 10);
        run_scen(nfill);

        // SUB and CLEAR together; SUB lingers after CLEAR lifts.
        nfill = 0; add(16'h8800, 12); add(16'h0800, 6); add(16'h0, 12);
        run_scen(nfill);

        // Key 2 with a rebounce inside the release window.
        nfill = 0; add(16'h0004, 10); add(16'h0, 2); add(16'h0004, 2);
        add(16'h0, 8); add(16'h0004, 10); add(16'h0, 10);
        run_scen(nfill);

        // Key 9: reset asserted mid-debounce, key held across reset.
        rst = 1'b1; key_raw = 16'h0200;
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_dbnc button", 32'(button), 32'h0);
        chk("rst_dbnc valid", 32'(button_valid), 32'h0);
        nfill = 0; add(16'h0200, 20); add(16'h0, 10);
        run_scen(nfill);

        // Async reset during HOLD must clear key_held before the next edge.
        rst = 1'b1; key_raw = 16'h0008;
        @(negedge clk); rst = 1'b0;
        repeat (D + 4) @(posedge clk);
        #1;
        chk("hold before rst", 32'(key_held), 32'h1);
        #2; rst = 1'b1; #1;
        chk("hold async rst held", 32'(key_held), 32'h0);
        chk("hold async rst button", 32'(button), 32'h0);
        key_raw = 16'h0;

        // Randomised key waveforms.
        for (int s = 0; s < 8; s++) begin
            nfill = 0;
            while (nfill < 150) begin
                r = $urandom_range(0, 5);
                v = 16'h1;
                case (r)
                    0, 1: v = 16'h0;
                    2, 3: v = v << $urandom_range(0, 15);
                    4:    v = (v << $urandom_range(0, 15)) | (v << $urandom_range(0, 15));
                    default: v = 16'($urandom);
                endcase
                add(v, $urandom_range(1, 2 * D + 3));
            end
            add(16'h0, 3 * D);
            run_scen(nfill);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
